ts_sync_framer: RTL
===================

TS_SYNC_FRAMER -- requirements
Module: ts_sync_framer

Interface
REQ-001 SHALL have parameter PACK_BYTE_SIZE, default 188, TS packet length in bytes.
REQ-002 SHALL have parameter LOCK_COUNT, default 3, consecutive sync bytes needed to lock (range 2..15).
REQ-003 SHALL have parameter UNLOCK_COUNT, default 3, consecutive missed sync bytes needed to drop lock (range 1..15).
REQ-004 SHALL have port mpeg_clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_data  in  8  raw TS byte from the tuner interface.
REQ-007 SHALL have port in_valid  in  1  in_data is valid this cycle.
REQ-008 SHALL have port mpeg_data  out  8  registered byte to the monitor.
REQ-009 SHALL have port mpeg_valid  out  1  registered copy of in_valid.
REQ-010 SHALL have port mpeg_sync  out  1  high on the first byte of each framed packet.
REQ-011 SHALL have port locked  out  1  high while the state is LOCKED.
REQ-012 SHALL have port sync_loss_count  out  32  number of LOCKED->HUNT transitions.

Function
REQ-013 SHALL register mpeg_data and mpeg_valid from in_data and in_valid with exactly 1 cycle latency; mpeg_sync SHALL share the same cycle as its byte.
REQ-014 SHALL advance all counters and the FSM only on cycles with in_valid=1; in_valid=0 cycles SHALL freeze state.
REQ-015 SHALL implement FSM states HUNT, VERIFY and LOCKED.
REQ-016 SHALL keep byte_pos (0..PACK_BYTE_SIZE-1), with position 0 being the expected sync byte; byte_pos SHALL wrap from PACK_BYTE_SIZE-1 to 0.
REQ-017 In HUNT, a valid byte of 8'h47 SHALL move the FSM to VERIFY with hits=1 and byte_pos=1; any other byte SHALL keep the FSM in HUNT.
REQ-018 In VERIFY, a valid byte at byte_pos=0 equal to 8'h47 SHALL increment hits; when hits reaches LOCK_COUNT, the FSM SHALL enter LOCKED.
REQ-019 In VERIFY, a valid byte at byte_pos=0 not equal to 8'h47 SHALL return the FSM to HUNT; that byte SHALL NOT be reconsidered as a new sync candidate.
REQ-020 In LOCKED, the byte at byte_pos=0 SHALL assert mpeg_sync whatever its value (flywheel).
REQ-021 In LOCKED, a byte at byte_pos=0 equal to 8'h47 SHALL clear misses; any other value SHALL increment misses.
REQ-022 In LOCKED, when misses reaches UNLOCK_COUNT the FSM SHALL go to HUNT next cycle, and sync_loss_count SHALL increment and saturate at 32'hFFFFFFFF.
REQ-023 The byte that completes lock (REQ-018) SHALL itself carry mpeg_sync=1.
REQ-024 mpeg_sync SHALL be 0 in HUNT and VERIFY, and SHALL never be 1 while mpeg_valid=0.
REQ-025 locked SHALL be a registered output, high in the cycle after entry to LOCKED and low in the cycle after exit.

Reset
REQ-026 rst=1 SHALL force the FSM to HUNT and clear byte_pos, hits and misses.
REQ-027 Reset SHALL drive mpeg_data=0, mpeg_valid=0, mpeg_sync=0, locked=0 and sync_loss_count=0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet, with no mpeg_sync until a fresh lock is achieved.

Configuration
REQ-029 With TS_SYNC_STATS_EN defined, sync_loss_count SHALL behave per REQ-022.
REQ-030 Without TS_SYNC_STATS_EN, sync_loss_count SHALL be tied to 0 and its counter SHALL not be built.

Structure
REQ-031 The shared package SHALL hold TS_SYNC_BYTE (8'h47), PACK_BYTE_SIZE default 188 and the FSM state encoding.
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 Scenario: 5 clean 188-byte packets after 7 junk bytes -> locked rises after the 3rd sync; mpeg_sync is 1 on the 3rd, 4th and 5th sync bytes.
REQ-034 Scenario: locked, with one packet whose byte 0 is 8'h00 -> mpeg_sync still pulses, locked stays 1, and misses clears on the next good sync.
REQ-035 Scenario: locked, then 3 consecutive bad sync bytes -> locked falls 1 cycle after the 3rd, and sync_loss_count=1.
REQ-036 Scenario: 8'h47 at offset 50 in HUNT followed by a non-8'h47 at offset 238 -> FSM returns to HUNT, and no lock occurs from that false candidate.
REQ-037 Scenario: clean stream with in_valid toggling 1,0,1,0 -> identical framing to the continuous stream, and mpeg_valid mirrors in_valid delayed by 1 cycle.
REQ-038 Scenario: rst pulsed at byte 100 of a locked packet -> all outputs 0 the next cycle; re-lock requires 3 fresh syncs.

Source files
------------

// File: rtl/ts_sync_framer_pkg.sv
// Shared constants for the MPEG-TS sync framer: the TS sync byte value,
// the default packet length and the framer FSM state encoding.
package ts_sync_framer_pkg;

  // Value every TS packet starts with.
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

  // PACK_BYTE_SIZE default: standard 188-byte transport stream packet.
  localparam int DEF_PACK_BYTE_SIZE = 188;

  // Framer FSM encoding, kept as plain constants so older tools and
  // netlist viewers see the same numbers.
  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage : ts_sync_framer_pkg

// File: rtl/ts_sync_framer.sv
// ts_sync_framer: finds the 0x47 sync byte in a raw transport stream,
// confirms it over LOCK_COUNT consecutive packets, then flywheels on the
// packet grid, flagging every packet start with mpeg_sync. Lock is dropped
// after UNLOCK_COUNT consecutive missing sync bytes.
// Optional feature: define TS_SYNC_STATS_EN to build the sync-loss counter;
// otherwise sync_loss_count is tied to zero.
module ts_sync_framer
  import ts_sync_framer_pkg::*;
#(
  parameter int PACK_BYTE_SIZE = DEF_PACK_BYTE_SIZE,
  parameter int LOCK_COUNT     = 3,
  parameter int UNLOCK_COUNT   = 3
) (
  input  logic        mpeg_clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [7:0]  mpeg_data,
  output logic        mpeg_valid,
  output logic        mpeg_sync,
  output logic        locked,
  output logic [31:0] sync_loss_count
);

  localparam int              POS_W    = (PACK_BYTE_SIZE > 1) ? $clog2(PACK_BYTE_SIZE) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PACK_BYTE_SIZE - 1);
  localparam logic [3:0]      LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0]      UNLOCK_N = 4'(UNLOCK_COUNT);

  logic [1:0]       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, pos_inc;
  logic [3:0]       hits_q, hits_d;
  logic [3:0]       misses_q, misses_d;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             sync_q, sync_d;
  logic             locked_q;

  logic is_sync;
  logic at_zero;
  logic miss_last;

  assign is_sync   = (in_data == TS_SYNC_BYTE);
  assign at_zero   = (pos_q == '0);
  assign miss_last = ((misses_q + 4'd1) == UNLOCK_N);
  assign pos_inc   = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);

  // Next-state logic: framing FSM, packet position and hit/miss counters.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    pos_d    = pos_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    sync_d   = 1'b0;

    // Cycles without a valid byte leave everything frozen.
    if (in_valid) begin
      pos_d = pos_inc;
      case (state_q)
        ST_HUNT: begin
          // Position stays pinned at 0 while hunting; a candidate sync
          // byte makes the next byte position 1.
          if (is_sync) begin
            state_d = ST_VERIFY;
            hits_d  = 4'd1;
          end else begin
            pos_d = '0;
          end
        end
        ST_VERIFY: begin
          if (at_zero) begin
            if (is_sync) begin
              hits_d = hits_q + 4'd1;
              if ((hits_q + 4'd1) == LOCK_N) begin
                state_d  = ST_LOCKED;
                misses_d = 4'd0;
                sync_d   = 1'b1;
              end
            end else begin
              // False candidate: drop it and hunt from the next byte on.
              state_d = ST_HUNT;
              pos_d   = '0;
              hits_d  = 4'd0;
            end
          end
        end
        ST_LOCKED: begin
          if (at_zero) begin
            // Flywheel: the grid position is trusted even if the byte is bad.
            sync_d = 1'b1;
            if (is_sync) begin
              misses_d = 4'd0;
            end else if (miss_last) begin
              state_d  = ST_HUNT;
              pos_d    = '0;
              hits_d   = 4'd0;
              misses_d = 4'd0;
            end else begin
              misses_d = misses_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          pos_d   = '0;
          hits_d  = 4'd0;
        end
      endcase
    end
  end

  // State and output registers; outputs line up with the byte they describe.
  always_ff @(posedge mpeg_clk) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      pos_q    <= '0;
      hits_q   <= 4'd0;
      misses_q <= 4'd0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      pos_q    <= pos_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      data_q   <= in_data;
      valid_q  <= in_valid;
      sync_q   <= sync_d;
      locked_q <= (state_d == ST_LOCKED);
    end
  end

  assign mpeg_data  = data_q;
  assign mpeg_valid = valid_q;
  assign mpeg_sync  = sync_q;
  assign locked     = locked_q;

`ifdef TS_SYNC_STATS_EN
  logic        loss_evt;
  logic [31:0] loss_cnt_q;

  assign loss_evt = in_valid && (state_q == ST_LOCKED) && at_zero && !is_sync && miss_last;

  // Saturating count of LOCKED -> HUNT transitions.
  always_ff @(posedge mpeg_clk) begin
    if (rst) begin
      loss_cnt_q <= 32'd0;
    end else if (loss_evt && (loss_cnt_q != 32'hFFFF_FFFF)) begin
      loss_cnt_q <= loss_cnt_q + 32'd1;
    end
  end

  assign sync_loss_count = loss_cnt_q;
`else
  assign sync_loss_count = 32'd0;
`endif

endmodule : ts_sync_framer
